// File: rtl/difftest_fp_wb_collector.sv
// Collects parallel FP register writebacks into a show-ahead FIFO and streams them
// one per cycle, in port order, to the difftest FP-writeback sink; drops on overflow.
module difftest_fp_wb_collector #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      io_in_valid,
    input  logic [8*NUM_PORTS-1:0]    io_in_addr,
    input  logic [64*NUM_PORTS-1:0]   io_in_data,
    input  logic [7:0]                io_coreid,
    input  logic                      io_out_ready,
    output logic                      enable,
    output logic                      io_out_valid,
    output logic [7:0]                io_out_address,
    output logic [63:0]               io_out_data,
    output logic [7:0]                io_out_coreid,
    output logic                      io_overflow,
    output logic [7:0]                io_drop_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = CW + 1;

    logic [7:0]    mem_addr [DEPTH];
    logic [63:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic                 deq;
    logic [NW-1:0]        free;
    logic [NW-1:0]        enq_n;
    logic [NW-1:0]        drop_n;
    logic [NUM_PORTS-1:0] wen;
    logic [AW-1:0]        widx [NUM_PORTS];
    logic [8:0]           drop_sum;

    // Lowest-index valid ports claim consecutive free slots; the rest are dropped.
    always_comb begin
        deq    = (count != '0) && io_out_ready;
        free   = NW'(DEPTH) - NW'(count) + NW'(deq);
        enq_n  = '0;
        drop_n = '0;
        wen    = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            widx[k] = wr_ptr + AW'(enq_n);
            if (io_in_valid[k]) begin
                if (enq_n < free) begin
                    wen[k] = 1'b1;
                    enq_n  = enq_n + NW'(1);
                end else begin
                    drop_n = drop_n + NW'(1);
                end
            end
        end
        drop_sum = 9'(io_drop_count) + 9'(drop_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            io_overflow   <= 1'b0;
            io_drop_count <= '0;
            io_out_coreid <= '0;
        end else begin
            rd_ptr        <= rd_ptr + AW'(deq);
            wr_ptr        <= wr_ptr + AW'(enq_n);
            count         <= count + CW'(enq_n) - CW'(deq);
            io_overflow   <= io_overflow | (drop_n != '0);
            io_drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            io_out_coreid <= io_coreid;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                if (wen[k]) begin
                    mem_addr[widx[k]] <= io_in_addr[8*k +: 8];
                    mem_data[widx[k]] <= io_in_data[64*k +: 64];
                end
            end
        end
    end

    assign io_out_valid   = (count != '0);
    assign enable         = io_out_valid;
    assign io_out_address = io_out_valid ? mem_addr[rd_ptr] : 8'h00;
    assign io_out_data    = io_out_valid ? mem_data[rd_ptr] : 64'h0;

endmodule

// File: tb/tb_difftest_fp_wb_collector.sv
// Directed and random bench for difftest_fp_wb_collector against a queue-based model.
module tb_difftest_fp_wb_collector;

    localparam int unsigned NP = 2;
    localparam int unsigned DP = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [NP-1:0] io_in_valid;
    logic [8*NP-1:0]  io_in_addr;
    logic [64*NP-1:0] io_in_data;
    logic [7:0]    io_coreid;
    logic          io_out_ready;
    logic          enable;
    logic          io_out_valid;
    logic [7:0]    io_out_address;
    logic [63:0]   io_out_data;
    logic [7:0]    io_out_coreid;
    logic          io_overflow;
    logic [7:0]    io_drop_count;

    difftest_fp_wb_collector #(.NUM_PORTS(NP), .DEPTH(DP)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_addr(io_in_addr), .io_in_data(io_in_data),
        .io_coreid(io_coreid), .io_out_ready(io_out_ready),
        .enable(enable), .io_out_valid(io_out_valid), .io_out_address(io_out_address),
        .io_out_data(io_out_data), .io_out_coreid(io_out_coreid),
        .io_overflow(io_overflow), .io_drop_count(io_drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t       q[$];
    int         exp_drops;
    logic       exp_ovf;
    logic [7:0] exp_core;
    int         errors;
    int         checks;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model at the edge, then compare all outputs.
    task automatic cyc(input logic rst, input logic [1:0] v,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic rdy);
        ent_t e;
        int   free;
        bit   deq;
        reset        = rst;
        io_in_valid  = v;
        io_in_addr   = {a1, a0};
        io_in_data   = {d1, d0};
        io_out_ready = rdy;
        io_coreid    = 8'($urandom);
        @(posedge clock);
        if (rst) begin
            q.delete();
            exp_drops = 0;
            exp_ovf   = 1'b0;
            exp_core  = 8'h00;
        end else begin
            exp_core = io_coreid;
            deq  = (q.size() > 0) && rdy;
            free = int'(DP) - q.size() + (deq ? 1 : 0);
            if (deq) void'(q.pop_front());
            for (int k = 0; k < 2; k++) begin
                if (v[k]) begin
                    if (free > 0) begin
                        e.a = (k == 0) ? a0 : a1;
                        e.d = (k == 0) ? d0 : d1;
                        q.push_back(e);
                        free--;
                    end else begin
                        exp_ovf = 1'b1;
                        if (exp_drops < 255) exp_drops++;
                    end
                end
            end
        end
        #1;
        check("valid",    64'(io_out_valid), 64'(q.size() > 0));
        check("enable",   64'(enable),       64'(q.size() > 0));
        check("address",  64'(io_out_address), (q.size() > 0) ? 64'(q[0].a) : 64'h0);
        check("data",     io_out_data,         (q.size() > 0) ? q[0].d : 64'h0);
        check("coreid",   64'(io_out_coreid),  64'(exp_core));
        check("overflow", 64'(io_overflow),    64'(exp_ovf));
        check("drops",    64'(io_drop_count),  64'(exp_drops));
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, rdy);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_drops = 0;
        exp_ovf   = 1'b0;
        exp_core  = 8'h00;

        // Reset state
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 1'b0);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 1'b0);

        // Single write then drain
        cyc(1'b0, 2'b01, 8'h05, 8'h00, 64'h3FF0000000000000, 64'h0, 1'b1);
        check("single_addr", 64'(io_out_address), 64'h05);
        idle(1'b1);
        check("single_empty", 64'(io_out_valid), 64'h0);

        // Dual-port same address ordering
        cyc(1'b0, 2'b11, 8'h01, 8'h01, 64'hA, 64'hB, 1'b1);
        check("dual_first", io_out_data, 64'hA);
        idle(1'b1);
        check("dual_second", io_out_data, 64'hB);
        idle(1'b1);

        // Back-pressure fill of 8, then 1 in / 1 out per cycle with wrap
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 2'b01, 8'(i), 8'h00, 64'(i), 64'h0, 1'b0);
        for (int i = 8; i < 16; i++)
            cyc(1'b0, 2'b01, 8'(i), 8'h00, 64'(i), 64'h0, 1'b1);
        check("wrap_no_ovf", 64'(io_overflow), 64'h0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Fill to 7, then overflow by one and saturate the drop counter
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 2'b01, 8'(8'h20 + i), 8'h00, 64'($urandom), 64'h0, 1'b0);
        cyc(1'b0, 2'b11, 8'h30, 8'h31, 64'h30, 64'h31, 1'b0);
        check("ovf_one", 64'(io_drop_count), 64'd1);
        for (int i = 0; i < 150; i++)
            cyc(1'b0, 2'b11, 8'h40, 8'h41, 64'h40, 64'h41, 1'b0);
        check("drop_sat", 64'(io_drop_count), 64'd255);

        // Full with simultaneous dequeue accepts port 0
        cyc(1'b0, 2'b01, 8'h50, 8'h00, 64'h50, 64'h0, 1'b1);
        check("full_deq_valid", 64'(io_out_valid), 64'h1);

        // Drain to 5 entries, then reset mid-stream with inputs valid
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 2'b11, 8'h77, 8'h78, 64'h77, 64'h78, 1'b1);
        check("rst_ovf", 64'(io_overflow), 64'h0);
        idle(1'b0);

        // Random traffic with mixed back-pressure
        for (int i = 0; i < 500; i++)
            cyc(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 10; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/difftest_fp_wb_collector.md
# difftest_fp_wb_collector

Producer side of the difftest FP-writeback channel. Captures floating-point register writebacks from the core's parallel FP writeback ports, buffers them in a FIFO, and emits them one per cycle in port order to the difftest FP-writeback sink. The sink receives `valid`/`address`/`data`/`coreid` plus an `enable` strobe. The block sits between the FP writeback stage and the difftest instance. It never back-pressures the core; if the FIFO overflows, writebacks are dropped and the drop is flagged.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of FP writeback ports, 1..4.
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `io_in_valid`  in  NUM_PORTS  per-port writeback valid.
- `io_in_addr`  in  8*NUM_PORTS  per-port FP register address; port k occupies bits [8k+7:8k].
- `io_in_data`  in  64*NUM_PORTS  per-port data; port k occupies bits [64k+63:64k].
- `io_coreid`  in  8  hart ID.
- `io_out_ready`  in  1  sink ready to consume the head entry.
- `enable`  out  1  strobe to the sink; equals `io_out_valid`.
- `io_out_valid`  out  1  FIFO non-empty.
- `io_out_address`  out  8  address of the head entry.
- `io_out_data`  out  64  data of the head entry.
- `io_out_coreid`  out  8  registered copy of `io_coreid`.
- `io_overflow`  out  1  sticky flag; set when any writeback has been dropped.
- `io_drop_count`  out  8  saturating count of dropped writebacks.

## Operation
- FIFO is show-ahead. Head entry is presented on `io_out_*` whenever `count != 0`.
- `io_out_address` and `io_out_data` read 0 when the FIFO is empty.
- Dequeue occurs when `io_out_valid && io_out_ready`. Read pointer advances by 1 and wraps modulo `DEPTH`.
- Enqueue:
  - In one cycle, all valid ports are written in ascending port index (port 0 first) at consecutive write-pointer slots, wrapping modulo `DEPTH`.
  - No merging: two ports writing the same address in one cycle produce two entries, port 0 first.
- Free space for the cycle is `DEPTH - count`, plus 1 if a dequeue occurs that cycle.
- Overflow:
  - If valid inputs exceed free space, the lowest-index valid ports that fit are enqueued and the rest are dropped.
  - `io_overflow` is set to 1 and stays set until reset.
  - `io_drop_count` increases by the number dropped and saturates at 255.
- Count update: `count_next = count + enq_n - deq`, where `enq_n` counts accepted entries only. `count` width is log2(DEPTH)+1.
- `io_out_coreid` is updated every cycle from `io_coreid`.
- Reset (synchronous, any cycle, including mid-stream):
  - pointers, `count`, `io_out_valid`, `enable`, `io_overflow`, `io_drop_count`, `io_out_coreid` go to 0;
  - `io_out_address` and `io_out_data` go to 0;
  - buffered entries are discarded;
  - inputs presented during the reset cycle are ignored.

## Timing
- Enqueue-to-output latency is 1 cycle. A writeback sampled at edge N appears on `io_out_*` after edge N, if the FIFO was empty.
- Throughput: 1 entry out per cycle. Sustained input above 1 valid per cycle fills the FIFO.
- Full FIFO with a simultaneous dequeue accepts 1 new entry that cycle.
- Empty FIFO with simultaneous input: no bypass. Output appears the next cycle.
- `enable` is identical to `io_out_valid` in every cycle.
- `io_overflow` and `io_drop_count` update at the same edge that drops the entry.

## Test plan
- Single write, `DEPTH=8`, `NUM_PORTS=2`: port0 addr 0x05, data 0x3FF0000000000000, `io_out_ready`=1. Response: next cycle `io_out_valid`=1, `enable`=1, addr 0x05, data 0x3FF0000000000000; following cycle `io_out_valid`=0 and addr/data read 0.
- Dual-port ordering: port0 addr 0x01, port1 addr 0x01 in the same cycle, with data 0xA and 0xB. Response: outputs 0xA then 0xB on consecutive cycles; `count` peaks at 2.
- Back-pressure and wrap: `io_out_ready`=0, enqueue 8 entries (addr 0..7). Then set ready=1 and enqueue 1 entry per cycle for 8 more. Response: strictly sequential addresses 0..15, no overflow, pointers wrap once.
- Overflow: FIFO holding 7 entries, ready=0, both ports valid. Response: port0 accepted, port1 dropped; `io_overflow`=1, `io_drop_count`=1. Repeat 300 drops: `io_drop_count` holds at 255.
- Full with simultaneous dequeue: `count`=8, ready=1, port0 valid only. Response: accepted, `count` stays 8, no overflow.
- Reset mid-stream: 5 entries buffered and `io_overflow`=1, assert reset for 1 cycle with inputs valid. Response: all outputs 0 the next cycle; inputs from the reset cycle never appear.
